// File: rtl/sdx_kernel_ctrl_mc.sv
// Kernel control sequencer: turns one ap_start into a single multi-channel run and gathers the channels' done pulses.
// Defining SDX_KERNEL_CTRL_PERF_CNT_EN adds a run-length cycle counter on perf_cycles.
module sdx_kernel_ctrl_mc #(
    parameter int C_NUM_CHANNELS    = 4,
    parameter int C_XFER_SIZE_WIDTH = 32,
    parameter int C_TIMEOUT_WIDTH   = 32
) (
    input  logic                         ap_clk,
    input  logic                         areset,
    input  logic                         ap_start,
    output logic                         ap_idle,
    output logic                         ap_done,
    output logic                         ap_ready,
    output logic                         ap_error,
    input  logic [C_NUM_CHANNELS-1:0]    ctrl_ch_enable,
    input  logic [C_XFER_SIZE_WIDTH-1:0] ctrl_xfer_size_in_bytes,
    input  logic [C_TIMEOUT_WIDTH-1:0]   ctrl_timeout_cycles,
    output logic [C_NUM_CHANNELS-1:0]    ch_start,
    output logic [C_XFER_SIZE_WIDTH-1:0] ch_xfer_size,
    input  logic [C_NUM_CHANNELS-1:0]    ch_done,
    output logic [C_NUM_CHANNELS-1:0]    ch_done_status,
    output logic [31:0]                  perf_cycles
);
    localparam logic [C_TIMEOUT_WIDTH-1:0] WDOG_ONE = C_TIMEOUT_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_DONE
    } state_t;

    state_t                      state;
    state_t                      state_next;
    logic                        ap_start_r;
    logic                        start_pulse;
    logic                        accept;
    logic                        run_timeout;
    logic                        timeout_hit;
    logic [C_NUM_CHANNELS-1:0]   mask_r;
    logic [C_NUM_CHANNELS-1:0]   status_upd;
    logic [C_TIMEOUT_WIDTH-1:0]  wdog;
    logic [C_TIMEOUT_WIDTH-1:0]  timeout_last;

    function automatic logic [C_TIMEOUT_WIDTH-1:0] wdog_sat_inc(input logic [C_TIMEOUT_WIDTH-1:0] v);
        return (v == '1) ? v : v + WDOG_ONE;
    endfunction

    assign start_pulse  = ap_start & ~ap_start_r;
    assign accept       = (state == S_IDLE) && start_pulse;
    // Out-of-mask done pulses never reach the status register.
    assign status_upd   = ch_done_status | (ch_done & mask_r);
    assign timeout_last = ctrl_timeout_cycles - WDOG_ONE;
    assign timeout_hit  = (ctrl_timeout_cycles != '0) && (wdog == timeout_last);

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        run_timeout = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_pulse) begin
                    state_next = (ctrl_ch_enable == '0) ? S_DONE : S_START;
                end
            end
            S_START: state_next = S_RUN;
            S_RUN: begin
                // Completion takes priority over a watchdog expiry in the same cycle.
                if (status_upd == mask_r) begin
                    state_next = S_DONE;
                end else if (timeout_hit) begin
                    run_timeout = 1'b1;
                    state_next  = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            ap_start_r     <= 1'b0;
            ap_idle        <= 1'b1;
            ap_done        <= 1'b0;
            ap_ready       <= 1'b0;
            ap_error       <= 1'b0;
            ch_start       <= '0;
            mask_r         <= '0;
            ch_xfer_size   <= '0;
            ch_done_status <= '0;
            wdog           <= '0;
        end else begin
            ap_start_r <= ap_start;
            ap_idle    <= (state_next == S_IDLE);
            ap_done    <= (state_next == S_DONE);
            ap_ready   <= (state_next == S_DONE);
            ch_start   <= accept ? ctrl_ch_enable : '0;

            if (accept) begin
                mask_r         <= ctrl_ch_enable;
                ch_xfer_size   <= ctrl_xfer_size_in_bytes;
                ch_done_status <= '0;
                ap_error       <= 1'b0;
            end else if ((state == S_START) || (state == S_RUN)) begin
                ch_done_status <= status_upd;
            end

            if (run_timeout) begin
                ap_error <= 1'b1;
            end

            if (state == S_START) begin
                wdog <= '0;
            end else if (state == S_RUN) begin
                wdog <= wdog_sat_inc(wdog);
            end
        end
    end

`ifdef SDX_KERNEL_CTRL_PERF_CNT_EN
    logic [31:0] perf_cnt;

    function automatic logic [31:0] perf_sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // perf_cnt holds the number of run cycles so far including the current one; the
    // DONE cycle is added when the result is captured so it is visible during DONE.
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            perf_cnt    <= '0;
            perf_cycles <= '0;
        end else begin
            if (accept && (state_next == S_START)) begin
                perf_cnt <= 32'd1;
            end else if (state != S_IDLE) begin
                perf_cnt <= perf_sat_inc(perf_cnt);
            end

            if (state_next == S_DONE) begin
                perf_cycles <= (state == S_IDLE) ? 32'd1 : perf_sat_inc(perf_cnt);
            end
        end
    end
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_sdx_kernel_ctrl_mc.sv
// Randomized scoreboard bench for sdx_kernel_ctrl_mc; run outcomes are predicted from start cycle,
// mask, per-channel done offsets and watchdog limit, then checked by an output monitor.
`timescale 1ns/1ps
module tb_sdx_kernel_ctrl_mc;
    localparam int NCH = 4;

    logic        ap_clk;
    logic        areset;
    logic        ap_start;
    logic        ap_idle;
    logic        ap_done;
    logic        ap_ready;
    logic        ap_error;
    logic [3:0]  ctrl_ch_enable;
    logic [31:0] ctrl_xfer_size_in_bytes;
    logic [31:0] ctrl_timeout_cycles;
    logic [3:0]  ch_start;
    logic [31:0] ch_xfer_size;
    logic [3:0]  ch_done;
    logic [3:0]  ch_done_status;
    logic [31:0] perf_cycles;

    typedef struct {
        int          t;
        int          done_cyc;
        int          perf;
        logic [3:0]  mask;
        logic [31:0] size;
        logic        err;
        logic [3:0]  status;
        bit          has_start;
        bit          seen_start;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] done_sched [int];
    int         offs [4];
    int         cyc = 0;
    int         last_sched = 0;
    int         done_cnt = 0;
    int         idle_chk = -1;
    int         errors = 0;
    int         checks = 0;
    logic       last_err = 1'b0;

    sdx_kernel_ctrl_mc dut (
        .ap_clk                  (ap_clk),
        .areset                  (areset),
        .ap_start                (ap_start),
        .ap_idle                 (ap_idle),
        .ap_done                 (ap_done),
        .ap_ready                (ap_ready),
        .ap_error                (ap_error),
        .ctrl_ch_enable          (ctrl_ch_enable),
        .ctrl_xfer_size_in_bytes (ctrl_xfer_size_in_bytes),
        .ctrl_timeout_cycles     (ctrl_timeout_cycles),
        .ch_start                (ch_start),
        .ch_xfer_size            (ch_xfer_size),
        .ch_done                 (ch_done),
        .ch_done_status          (ch_done_status),
        .perf_cycles             (perf_cycles)
    );

    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    always @(posedge ap_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_ap_idle"}, 32'(ap_idle), 32'd1);
        chk({tag, "_ap_done"}, 32'(ap_done), 32'd0);
        chk({tag, "_ap_ready"}, 32'(ap_ready), 32'd0);
        chk({tag, "_ap_error"}, 32'(ap_error), 32'd0);
        chk({tag, "_ch_start"}, 32'(ch_start), 32'd0);
        chk({tag, "_ch_done_status"}, 32'(ch_done_status), 32'd0);
        chk({tag, "_ch_xfer_size"}, ch_xfer_size, 32'd0);
        chk({tag, "_perf_cycles"}, perf_cycles, 32'd0);
    endtask

    task automatic sched_add(input int c, input int ch);
        logic [3:0] b;
        b = done_sched.exists(c) ? done_sched[c] : 4'b0;
        b[ch] = 1'b1;
        done_sched[c] = b;
        if (c > last_sched) last_sched = c;
    endtask

    // Predicts one run from the accepted start cycle t and the channel done offsets.
    task automatic launch(input logic [3:0] mask, input logic [31:0] size, input int tmo);
        exp_t       e;
        int         t;
        int         comp;
        int         detect;
        bit         incomplete;
        logic [3:0] st;
        t = cyc;
        ap_start = 1'b1;
        ctrl_ch_enable = mask;
        ctrl_xfer_size_in_bytes = size;
        ctrl_timeout_cycles = 32'(tmo);
        comp = t + 1;
        incomplete = 1'b0;
        st = 4'b0;
        for (int i = 0; i < NCH; i++) begin
            if (offs[i] >= 0) sched_add(t + 1 + offs[i], i);
            if (mask[i]) begin
                if (offs[i] < 0) incomplete = 1'b1;
                else if (t + 1 + offs[i] > comp) comp = t + 1 + offs[i];
                if (offs[i] >= 0 && offs[i] <= tmo) st[i] = 1'b1;
            end
        end
        e.t = t;
        e.mask = mask;
        e.size = size;
        e.has_start = (mask != 4'b0);
        e.seen_start = 1'b0;
        if (mask == 4'b0) begin
            e.done_cyc = t + 1;
            e.err = 1'b0;
            e.status = 4'b0;
        end else begin
            detect = (comp < t + 2) ? t + 2 : comp;
            if (tmo != 0 && (incomplete || detect > t + 1 + tmo)) begin
                e.done_cyc = t + 2 + tmo;
                e.err = 1'b1;
                e.status = st;
            end else begin
                e.done_cyc = detect + 1;
                e.err = 1'b0;
                e.status = mask;
            end
        end
`ifdef SDX_KERNEL_CTRL_PERF_CNT_EN
        e.perf = e.done_cyc - t;
`else
        e.perf = 0;
`endif
        sb.push_back(e);
    endtask

    task automatic settle();
        while (cyc <= last_sched + 1) begin
            @(posedge ap_clk); #1;
        end
        @(posedge ap_clk); #1;
    endtask

    task automatic do_run(input logic [3:0] mask, input logic [31:0] size, input int tmo,
                          input bit hold, input bit glitch);
        int target;
        int n;
        int t0;
        target = done_cnt + 1;
        t0 = cyc;
        launch(mask, size, tmo);
        @(posedge ap_clk); #1;
        ctrl_ch_enable = 4'($urandom);
        ctrl_xfer_size_in_bytes = $urandom;
        if (!hold) ap_start = 1'b0;
        if (glitch && !hold) begin
            @(posedge ap_clk); #1;
            @(posedge ap_clk); #1;
            ap_start = 1'b1;
            @(posedge ap_clk); #1;
            ap_start = 1'b0;
        end
        n = 0;
        while (done_cnt < target && n < 600) begin
            @(posedge ap_clk); #1;
            n++;
        end
        checks++;
        if (done_cnt < target) begin
            errors++;
            $display("FAIL run_completion: run started at cycle %0d gave no ap_done within %0d cycles, expected one", t0, n);
            sb.delete();
        end
        if (hold) begin
            repeat (3) begin
                @(posedge ap_clk); #1;
            end
            ap_start = 1'b0;
        end
        settle();
    endtask

    initial begin
        ch_done = 4'b0;
        forever begin
            @(posedge ap_clk); #1;
            ch_done = done_sched.exists(cyc) ? done_sched[cyc] : 4'b0;
        end
    end

    initial begin : monitor
        exp_t       e;
        logic [3:0] exp_cs;
        bit         exp_done;
        forever begin
            @(negedge ap_clk);
            if (cyc == idle_chk) begin
                chk("ap_idle_after_done", 32'(ap_idle), 32'd1);
                chk("ap_error_sticky", 32'(ap_error), 32'(last_err));
            end
            exp_cs = 4'b0;
            if (sb.size() > 0 && sb[0].has_start && (sb[0].t + 1 == cyc)) exp_cs = sb[0].mask;
            if (ch_start != 4'b0 || exp_cs != 4'b0) begin
                chk("ch_start", 32'(ch_start), 32'(exp_cs));
                if (exp_cs != 4'b0) begin
                    sb[0].seen_start = 1'b1;
                    chk("ch_xfer_size", ch_xfer_size, sb[0].size);
                    chk("ap_idle_in_start", 32'(ap_idle), 32'd0);
                    chk("ap_error_cleared", 32'(ap_error), 32'd0);
                end
            end
            exp_done = (sb.size() > 0) && (sb[0].done_cyc == cyc);
            if (ap_done || ap_ready || exp_done) begin
                chk("ap_done", 32'(ap_done), 32'(exp_done));
                chk("ap_ready", 32'(ap_ready), 32'(exp_done));
                if (sb.size() > 0 && (ap_done || exp_done)) begin
                    e = sb.pop_front();
                    chk("ap_error", 32'(ap_error), 32'(e.err));
                    chk("ch_done_status", 32'(ch_done_status), 32'(e.status));
                    chk("ap_idle_in_done", 32'(ap_idle), 32'd0);
                    chk("ch_start_seen", 32'(e.seen_start), 32'(e.has_start));
                    chk("perf_cycles", perf_cycles, 32'(e.perf));
                    last_err = e.err;
                    idle_chk = cyc + 1;
                    done_cnt++;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "bench did not finish");
    end

    initial begin
        logic [3:0] m;
        int         tmo;
        bit         hold;
        bit         glitch;
        ap_start = 1'b0;
        areset = 1'b1;
        ctrl_ch_enable = 4'b0;
        ctrl_xfer_size_in_bytes = 32'd0;
        ctrl_timeout_cycles = 32'd0;
        repeat (3) @(posedge ap_clk);
        @(negedge ap_clk);
        chk_reset_values("reset");
        @(posedge ap_clk); #1;
        areset = 1'b0;
        @(posedge ap_clk); #1;

        // all channels, staggered completion
        offs = '{5, 9, 9, 20};
        do_run(4'b1111, 32'd16384, 0, 1'b0, 1'b0);
        // partial mask, channel 1 done must be ignored
        offs = '{3, 1, 8, -1};
        do_run(4'b0101, 32'd4096, 0, 1'b0, 1'b0);
        // empty mask
        offs = '{2, -1, -1, -1};
        do_run(4'b0000, 32'd77, 0, 1'b0, 1'b0);
        // watchdog expiry, channel 3 never completes
        offs = '{10, 20, 30, -1};
        do_run(4'b1111, 32'd512, 100, 1'b0, 1'b0);
        // zero-latency completion, clears the error flag
        offs = '{0, 0, -1, -1};
        do_run(4'b0011, 32'd64, 0, 1'b0, 1'b0);
        // ap_start held through done, then a second run
        offs = '{-1, -1, -1, 4};
        do_run(4'b1000, 32'd8, 0, 1'b1, 1'b0);
        offs = '{-1, 6, 2, -1};
        do_run(4'b0110, 32'd128, 0, 1'b0, 1'b0);
        // completion and watchdog in the same cycle, then one cycle late
        offs = '{5, -1, -1, -1};
        do_run(4'b0001, 32'd1, 5, 1'b0, 1'b0);
        offs = '{6, -1, -1, -1};
        do_run(4'b0001, 32'd2, 5, 1'b0, 1'b0);
        // uniform completion at +10
        offs = '{10, 10, 10, 10};
        do_run(4'b1111, 32'd1024, 0, 1'b0, 1'b0);

        // reset in the middle of a run
        offs = '{2, 50, 50, 50};
        launch(4'b1111, 32'd99, 0);
        @(posedge ap_clk); #1;
        ap_start = 1'b0;
        repeat (4) begin
            @(posedge ap_clk); #1;
        end
        areset = 1'b1;
        sb.delete();
        @(posedge ap_clk); #1;
        areset = 1'b0;
        @(negedge ap_clk);
        chk_reset_values("midrun_reset");
        #1;
        settle();

        for (int k = 0; k < 24; k++) begin
            m = 4'($urandom_range(0, 15));
            tmo = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 40));
            for (int i = 0; i < NCH; i++) begin
                offs[i] = ($urandom_range(0, 6) == 0) ? -1 : int'($urandom_range(0, 30));
                if (tmo == 0 && m[i] && offs[i] < 0) offs[i] = int'($urandom_range(0, 30));
            end
            hold = ($urandom_range(0, 3) == 0);
            glitch = (m != 4'b0) && !hold && ($urandom_range(0, 1) == 1);
            do_run(m, $urandom, tmo, hold, glitch);
        end

        offs = '{1, 2, 3, 4};
        do_run(4'b1111, 32'd2048, 0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
